// File: rtl/ext_mem_controller_pkg.sv
// Shared definitions for the external memory controller.
// State encodings, latency limits and default word width.
package ext_mem_controller_pkg;

    localparam int MC_WORD_SIZE = 32;
    localparam int MC_LAT_MIN   = 1;
    localparam int MC_LAT_MAX   = 15;
    localparam int MC_CNT_W     = 4;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_WAIT = 2'd1,
        MC_ACK  = 2'd2
    } mc_state_t;

endpackage

// File: rtl/ext_mem_controller_sync_ram.sv
// Backing array for the external memory controller.
// One bus write port, one synchronous read port, one backdoor write port.
module sync_ram
    import ext_mem_controller_pkg::*;
#(
    parameter int WIDTH = MC_WORD_SIZE,
    parameter int ABITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [ABITS-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic             init_we,
    input  logic [ABITS-1:0] init_addr,
    input  logic [WIDTH-1:0] init_data
);

    logic [WIDTH-1:0] mem [2**ABITS];

    // Array update; the bus write comes last so it overrides a backdoor hit
    always_ff @(posedge clk) begin
        if (init_we) mem[init_addr] <= init_data;
        if (we)      mem[addr]      <= wdata;
    end

    // Read register: write data on bus writes, old contents on reads, else 0
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (we) rdata <= wdata;
        else if (re) rdata <= mem[addr];
        else         rdata <= '0;
    end

endmodule

// File: rtl/ext_mem_controller.sv
// Word-addressed backing memory on the external port.
// Accepts one request, waits LATENCY cycles, then pulses mem_ready.
module ext_mem_controller
    import ext_mem_controller_pkg::*;
#(
    parameter int WORD_SIZE = MC_WORD_SIZE,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_addr,
    input  logic                 en_ext_mem_re,
    input  logic                 en_ext_mem_wr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 mem_ready,
    output logic                 addr_error,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [WORD_SIZE-1:0] init_data
);

    if (LATENCY < MC_LAT_MIN || LATENCY > MC_LAT_MAX) begin : g_bad_latency
        $error("ext_mem_controller: LATENCY out of range");
    end

    localparam bit DIRECT = (LATENCY == 1);
    localparam logic [MC_CNT_W-1:0] CNT_INIT = MC_CNT_W'(LATENCY - 1);

    mc_state_t             state;
    logic [MC_CNT_W-1:0]   cnt;
    logic [ADDR_BITS-1:0]  idx_q;
    logic                  oob_q;
    logic                  wr_q;
    logic [WORD_SIZE-1:0]  wdata_q;

    logic                  req;
    logic [ADDR_BITS-1:0]  in_idx;
    logic                  in_oob;
    logic                  idle_ack;
    logic                  wait_ack;
    logic                  go_ack;
    logic                  is_idle;
    logic [ADDR_BITS-1:0]  acc_idx;
    logic                  acc_oob;
    logic                  acc_wr;
    logic [WORD_SIZE-1:0]  acc_data;
    logic                  ram_we;
    logic                  ram_re;
    logic [1:0]            unused_addr_lsb;

    assign unused_addr_lsb = mem_addr[1:0];

    assign req    = en_ext_mem_re | en_ext_mem_wr;
    assign in_idx = mem_addr[ADDR_BITS+1:2];
    assign in_oob = |mem_addr[31:ADDR_BITS+2];

    // With LATENCY=1 the ACK edge is the acceptance edge, so live inputs
    // feed the array; otherwise the latched request does.
    assign is_idle  = (state == MC_IDLE);
    assign idle_ack = is_idle && req && DIRECT;
    assign wait_ack = (state == MC_WAIT) && req && (cnt == '0);
    assign go_ack   = !rst && (idle_ack || wait_ack);

    assign acc_idx  = is_idle ? in_idx        : idx_q;
    assign acc_oob  = is_idle ? in_oob        : oob_q;
    assign acc_wr   = is_idle ? en_ext_mem_wr : wr_q;
    assign acc_data = is_idle ? data_in       : wdata_q;

    assign ram_we = go_ack && acc_wr && !acc_oob;
    assign ram_re = go_ack && !acc_oob;

    // Request FSM: accept, count wait states, one-cycle acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MC_IDLE;
            cnt        <= '0;
            mem_ready  <= 1'b0;
            addr_error <= 1'b0;
            idx_q      <= '0;
            oob_q      <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            unique case (state)
                MC_IDLE: begin
                    mem_ready  <= 1'b0;
                    addr_error <= 1'b0;
                    if (req) begin
                        idx_q   <= in_idx;
                        oob_q   <= in_oob;
                        wr_q    <= en_ext_mem_wr;
                        wdata_q <= data_in;
                        cnt     <= CNT_INIT;
                        if (DIRECT) begin
                            state      <= MC_ACK;
                            mem_ready  <= 1'b1;
                            addr_error <= in_oob;
                        end else begin
                            state <= MC_WAIT;
                        end
                    end
                end
                MC_WAIT: begin
                    if (!req) begin
                        state <= MC_IDLE;
                    end else if (cnt == '0) begin
                        state      <= MC_ACK;
                        mem_ready  <= 1'b1;
                        addr_error <= oob_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MC_ACK: begin
                    state      <= MC_IDLE;
                    mem_ready  <= 1'b0;
                    addr_error <= 1'b0;
                end
                default: begin
                    state      <= MC_IDLE;
                    mem_ready  <= 1'b0;
                    addr_error <= 1'b0;
                end
            endcase
        end
    end

    sync_ram #(
        .WIDTH (WORD_SIZE),
        .ABITS (ADDR_BITS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we        (ram_we),
        .re        (ram_re),
        .addr      (acc_idx),
        .wdata     (acc_data),
        .rdata     (data_out),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

endmodule

// File: tb/tb_ext_mem_controller.sv
// Self-checking bench for ext_mem_controller.
// Random and directed accesses against an array reference model.
module tb_ext_mem_controller;

    localparam int LAT_A = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_addr, a_din, a_dout, a_idata;
    logic        a_re, a_wr, a_rdy, a_err, a_iwe;
    logic [9:0]  a_iaddr;

    logic [31:0] b_addr, b_din, b_dout, b_idata;
    logic        b_re, b_wr, b_rdy, b_err, b_iwe;
    logic [9:0]  b_iaddr;

    int checks = 0;
    int errors = 0;

    logic [31:0] model   [1024];
    logic [31:0] model_b [8];

    always #5 clk = ~clk;

    ext_mem_controller #(.WORD_SIZE(32), .ADDR_BITS(10), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .mem_addr(a_addr),
        .en_ext_mem_re(a_re), .en_ext_mem_wr(a_wr), .data_in(a_din),
        .data_out(a_dout), .mem_ready(a_rdy), .addr_error(a_err),
        .init_we(a_iwe), .init_addr(a_iaddr), .init_data(a_idata)
    );

    ext_mem_controller #(.WORD_SIZE(32), .ADDR_BITS(10), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .mem_addr(b_addr),
        .en_ext_mem_re(b_re), .en_ext_mem_wr(b_wr), .data_in(b_din),
        .data_out(b_dout), .mem_ready(b_rdy), .addr_error(b_err),
        .init_we(b_iwe), .init_addr(b_iaddr), .init_data(b_idata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on dut_a; inputs scrambled while waiting, optional
    // backdoor write to the same word on the edge that enters ACK.
    task automatic acc_a(input logic [31:0] addr, input bit do_wr,
                         input bit both, input logic [31:0] wd,
                         input bit collide);
        bit          seen;
        logic [9:0]  idx;
        bit          oob;
        logic [31:0] exp_d;
        logic [31:0] bd;
        int          exp_n;
        idx   = addr[11:2];
        oob   = |addr[31:12];
        exp_n = (LAT_A == 1) ? 1 : LAT_A + 1;
        bd    = $urandom;
        seen  = 1'b0;
        @(negedge clk);
        a_addr = addr;
        a_din  = wd;
        a_re   = !do_wr || both;
        a_wr   = do_wr;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            a_iwe = 1'b0;
            if (a_rdy) begin
                seen = 1'b1;
                chk("latency", 32'(n), 32'(exp_n));
                if (oob)        exp_d = 32'h0;
                else if (do_wr) exp_d = wd;
                else            exp_d = model[idx];
                chk("data_out", a_dout, exp_d);
                chk("addr_error", 32'(a_err), 32'(oob));
                if (!oob && do_wr) model[idx] = wd;
                if (collide && (oob || !do_wr)) model[idx] = bd;
                a_re = 1'b0;
                a_wr = 1'b0;
            end else begin
                a_addr = $urandom;
                a_din  = $urandom;
                if (collide && n == LAT_A) begin
                    a_iwe   = 1'b1;
                    a_iaddr = idx;
                    a_idata = bd;
                end
            end
        end
        if (!seen) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("pulse", 32'({a_rdy, a_err}), 32'd0);
        chk("data_out_idle", a_dout, 32'h0);
    endtask

    // Write that is abandoned in WAIT, by dropping the request or by reset
    task automatic abort_a(input int idx, input bit use_rst);
        int seen = 0;
        @(negedge clk);
        a_addr = {20'h0, 10'(idx), 2'b00};
        a_din  = ~model[idx];
        a_wr   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         a_wr = 1'b0;
        @(negedge clk);
        if (use_rst) begin
            rst  = 1'b0;
            a_wr = 1'b0;
            chk("rst_outputs", 32'({a_rdy, a_err}), 32'd0);
            chk("rst_data_out", a_dout, 32'h0);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (a_rdy) seen++;
        end
        chk(use_rst ? "rst_no_ready" : "abort_no_ready", 32'(seen), 32'd0);
        acc_a({20'h0, 10'(idx), 2'b00}, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        a_addr = '0; a_din = '0; a_re = 1'b0; a_wr = 1'b0;
        a_iwe = 1'b0; a_iaddr = '0; a_idata = '0;
        b_addr = '0; b_din = '0; b_re = 1'b0; b_wr = 1'b0;
        b_iwe = 1'b0; b_iaddr = '0; b_idata = '0;
        repeat (3) @(negedge clk);
        chk("reset_a", 32'({a_rdy, a_err}), 32'd0);
        chk("reset_a_data", a_dout, 32'h0);
        chk("reset_b", 32'({b_rdy, b_err}), 32'd0);
        chk("reset_b_data", b_dout, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            model[i] = (i == 5) ? 32'hDEADBEEF : $urandom;
            a_iwe   = 1'b1;
            a_iaddr = 10'(i);
            a_idata = model[i];
            if (i < 8) begin
                model_b[i] = $urandom;
                b_iwe   = 1'b1;
                b_iaddr = 10'(i);
                b_idata = model_b[i];
            end else begin
                b_iwe = 1'b0;
            end
            @(negedge clk);
        end
        a_iwe = 1'b0;
        b_iwe = 1'b0;

        acc_a(32'h14, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_a(32'h20, 1'b1, 1'b0, 32'h12345678, 1'b0);
        acc_a(32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_a(32'h08, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0);
        acc_a(32'h08, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_a(32'h1000, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_a(32'h1000, 1'b1, 1'b0, 32'hFFFF0000, 1'b0);
        acc_a(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        abort_a(9, 1'b0);
        abort_a(10, 1'b1);
        acc_a(32'h30, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1);
        acc_a(32'h30, 1'b0, 1'b0, 32'h0, 1'b0);
        acc_a(32'h34, 1'b0, 1'b0, 32'h0, 1'b1);
        acc_a(32'h34, 1'b0, 1'b0, 32'h0, 1'b0);

        @(negedge clk);
        b_addr = 32'h4;
        b_re   = 1'b1;
        @(negedge clk);
        chk("b_ready1", 32'(b_rdy), 32'd1);
        chk("b_data1", b_dout, model_b[1]);
        b_addr = 32'h8;
        @(negedge clk);
        chk("b_gap", 32'(b_rdy), 32'd0);
        chk("b_gap_data", b_dout, 32'h0);
        @(negedge clk);
        chk("b_ready2", 32'(b_rdy), 32'd1);
        chk("b_data2", b_dout, model_b[2]);
        b_re = 1'b0;
        @(negedge clk);
        chk("b_idle", 32'(b_rdy), 32'd0);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] ad;
            bit          w;
            bit          bo;
            bit          c;
            ad = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0)
                ad[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            w  = 1'($urandom_range(0, 1));
            bo = w && ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 5) == 0);
            acc_a(ad, w, bo, $urandom, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
